// File: rtl/divider_pkg.sv
// Shared widths, step count and FSM state type
// for the radix-2 restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = 6;

  localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step:
// shift, trial subtract, restore on borrow.
import divider_pkg::*;

module divider_step (
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic [DIV_WIDTH-1:0] dvd_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic [DIV_WIDTH-1:0] dvd_o
);

  logic [DIV_WIDTH:0] shl;
  logic [DIV_WIDTH:0] trial;
  logic               borrow;

  assign shl   = {rem_i, dvd_i[DIV_WIDTH-1]};
  assign trial = shl - {1'b0, dvs_i};

  // rem_i < dvs_i always holds, so a borrow
  // shows up as the top trial bit.
  assign borrow = trial[DIV_WIDTH];

  assign rem_o = borrow ? shl[DIV_WIDTH-1:0]
                        : trial[DIV_WIDTH-1:0];
  assign dvd_o = {dvd_i[DIV_WIDTH-2:0], ~borrow};

endmodule

// File: rtl/divider_32.sv
// Unsigned 32-bit sequential divider, one
// quotient bit per clock, 33-edge latency.
import divider_pkg::*;

module divider_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        ena,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        dne
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] q_q, q_d;
  logic [DIV_WIDTH-1:0] r_q, r_d;
  logic                 dne_q, dne_d;

  logic [DIV_WIDTH-1:0] step_rem;
  logic [DIV_WIDTH-1:0] step_dvd;

  divider_step u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .dvd_o (step_dvd)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_d     = q_q;
    r_d     = r_q;
    dne_d   = dne_q;
    unique case (state_q)
      IDLE: begin
        dne_d = 1'b0;
        if (ena) begin
          dvd_d   = a;
          dvs_d   = b;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!ena) begin
          dne_d   = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LAST_STEP) begin
            q_d     = step_dvd;
            r_d     = step_rem;
            dne_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!ena) begin
          dne_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        dne_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dne_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dne_q   <= dne_d;
    end
  end

  assign q   = q_q;
  assign r   = r_q;
  assign dne = dne_q;

endmodule

// File: tb/tb_divider_32.sv
// Directed self-checking bench for divider_32
// with hand-computed quotient/remainder vectors.
module tb_divider_32;

  logic        clk;
  logic        rst;
  logic        ena;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] q;
  logic [31:0] r;
  logic        dne;

  int errors;
  int checks;

  logic [31:0] prev_q;
  logic [31:0] prev_r;

  divider_32 dut (
    .clk (clk),
    .rst (rst),
    .ena (ena),
    .a   (a),
    .b   (b),
    .q   (q),
    .r   (r),
    .dne (dne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag,
                         input logic [31:0] av,
                         input logic [31:0] bv,
                         input logic [31:0] eq,
                         input logic [31:0] er);
    a   = av;
    b   = bv;
    ena = 1'b1;
    tick(32);
    chk({tag, "_dne_early"}, {31'd0, dne}, 32'd0);
    chk({tag, "_q_busy"}, q, prev_q);
    chk({tag, "_r_busy"}, r, prev_r);
    tick(1);
    chk({tag, "_dne"}, {31'd0, dne}, 32'd1);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic drop(input string tag);
    ena = 1'b0;
    tick(1);
    chk({tag, "_dne_drop"}, {31'd0, dne}, 32'd0);
    chk({tag, "_q_drop"}, q, prev_q);
    chk({tag, "_r_drop"}, r, prev_r);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    prev_q = '0;
    prev_r = '0;
    rst = 1'b0;
    ena = 1'b0;
    a   = '0;
    b   = '0;
    tick(2);
    chk("rst_q", q, 32'd0);
    chk("rst_r", r, 32'd0);
    chk("rst_dne", {31'd0, dne}, 32'd0);
    rst = 1'b1;
    tick(1);

    run_div("d155_25", 32'd155, 32'd25, 32'd6, 32'd5);
    a = 32'd1000;
    b = 32'd3;
    tick(5);
    chk("hold_dne", {31'd0, dne}, 32'd1);
    chk("hold_q", q, 32'd6);
    chk("hold_r", r, 32'd5);
    drop("d155_25");

    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1,
            32'hFFFF_FFFF, 32'd0);
    drop("dmax_1");
    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2);
    drop("d100_7");

    run_div("d7_0", 32'd7, 32'd0,
            32'hFFFF_FFFF, 32'd7);
    drop("d7_0");
    run_div("d5_9", 32'd5, 32'd9, 32'd0, 32'd5);
    drop("d5_9");
    run_div("d0_3", 32'd0, 32'd3, 32'd0, 32'd0);
    drop("d0_3");

    // asynchronous reset mid-division
    a   = 32'd155;
    b   = 32'd25;
    ena = 1'b1;
    tick(10);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_q", q, 32'd0);
    chk("arst_r", r, 32'd0);
    chk("arst_dne", {31'd0, dne}, 32'd0);
    prev_q = '0;
    prev_r = '0;
    ena = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    run_div("post_rst", 32'd155, 32'd25, 32'd6, 32'd5);
    drop("post_rst");

    // abort at iteration 20
    run_div("pre_abort", 32'd100, 32'd7, 32'd14, 32'd2);
    drop("pre_abort");
    a   = 32'd155;
    b   = 32'd25;
    ena = 1'b1;
    tick(21);
    drop("abort");
    run_div("rerun", 32'd155, 32'd25, 32'd6, 32'd5);
    drop("rerun");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/divider_32.md
# divider_32

Unsigned 32-bit sequential divider in the ALU datapath, computing quotient and remainder of `a / b` with a radix-2 restoring algorithm, one quotient bit per clock. The parent control logic enables the block, holds operands stable, and waits for `dne` before sampling `q`/`r`. Fixed latency: 33 rising edges from operand capture to `dne`.

## Interface
- Parameters: none. Width fixed at 32.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ena`  in  1  enable/start; high requests a division, low aborts and idles.
- `a`  in  32  dividend, unsigned; sampled on the load edge only.
- `b`  in  32  divisor, unsigned; sampled on the load edge only.
- `q`  out  32  quotient; registered.
- `r`  out  32  remainder; registered.
- `dne`  out  1  result valid; registered.

## Operation
- States: IDLE, BUSY, DONE.
- `rst`=0 (any time, including mid-division): state IDLE, `q`=0, `r`=0, `dne`=0, counter=0, internal working registers=0.
- IDLE:
  - `ena`=1 at an edge: capture `a` into the working dividend, `b` into the divisor, clear the partial remainder, counter=0; go to BUSY.
  - `ena`=0: stay in IDLE.
- BUSY, each edge with `ena`=1: perform one restoring step.
  - Shift {partial remainder, dividend} left 1.
  - Trial = remainder[32:0] − {1'b0, divisor}, using a 33-bit subtract.
  - If no borrow, remainder = trial and the shifted-in quotient bit = 1; otherwise keep the remainder and the bit = 0.
  - Counter increments.
  - On the 32nd step, write the final quotient/remainder to `q`/`r`, set `dne`=1, go to DONE.
- BUSY with `ena`=0: abort, go to IDLE with `dne`=0; `q`/`r` keep their previous values.
- DONE:
  - Hold `q`, `r` and `dne`=1 while `ena`=1. Operand changes are ignored.
  - `ena`=0: go to IDLE and clear `dne` (`q`/`r` hold).
  - A new division requires `ena` low for at least one edge.
- Divide by zero needs no special case. The algorithm naturally yields `q`=32'hFFFF_FFFF and `r`=`a`, and this is the required result.
- `q` and `r` change only at the completing edge (or on reset), never during BUSY.

## Timing
- Edge L (IDLE, `ena`=1): load.
- Edges L+1 … L+32: iterations.
- `dne` rises after edge L+32, i.e. latency is 33 edges.
- `dne` falls one edge after `ena` is deasserted.
- Reset is asynchronous; release is synchronized by the user.
- All outputs are registered; no combinational input-to-output path.

## Structure
- Package `divider_pkg`:
  - `DIV_WIDTH`=32.
  - Counter width: 6 bits.
  - State enum {IDLE, BUSY, DONE}.
- Sub-module `divider_step`: purely combinational single restoring step.
  - Inputs: remainder, dividend, divisor.
  - Outputs: next remainder, next dividend/quotient.
- The top contains the FSM, counter, working registers and output registers.

## Test plan
- `a`=155, `b`=25, `ena` raised → after 33 edges `dne`=1, `q`=6, `r`=5; outputs stay stable for 5 more edges with `ena` held.
- `a`=32'hFFFF_FFFF, `b`=1 → `q`=32'hFFFF_FFFF, `r`=0. Then drop `ena` one edge, `a`=100, `b`=7 → `q`=14, `r`=2.
- `a`=7, `b`=0 → `q`=32'hFFFF_FFFF, `r`=7, `dne` at edge 33.
- `a`=5, `b`=9 → `q`=0, `r`=5. `a`=0, `b`=3 → `q`=0, `r`=0.
- `rst` low asynchronously at iteration 10 → `q`=0, `r`=0, `dne`=0 immediately. Release, then a fresh 155/25 → correct after 33 edges.
- `ena` dropped at iteration 20 of 155/25 → IDLE, `dne`=0, `q`/`r` unchanged. Re-raise → full 33-edge run, correct result.
